// File: rtl/membus_pkg.sv
// Shared constants, FSM state type and byte-enable helpers for the 32-to-16 bit memory bus bridge.
package membus_pkg;

    localparam int MEM_AW  = 20;
    localparam int MEM_DW  = 16;
    localparam int CORE_AW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } membr_state_t;

    function automatic logic [1:0] half_be(input logic [3:0] be, input logic h);
        return h ? be[3:2] : be[1:0];
    endfunction

    function automatic logic half_needed(input logic [3:0] be, input logic h);
        return |half_be(be, h);
    endfunction

endpackage

// File: rtl/mem_half_merge.sv
// Byte-lane merge of new store data into an old halfword, used by read-modify-write stores.
module mem_half_merge
    import membus_pkg::*;
(
    input  logic [MEM_DW-1:0] i_old,
    input  logic [MEM_DW-1:0] i_new,
    input  logic [1:0]        i_be,
    output logic [MEM_DW-1:0] o_merged
);

    assign o_merged = {i_be[1] ? i_new[15:8] : i_old[15:8],
                       i_be[0] ? i_new[7:0]  : i_old[7:0]};

endmodule

// File: rtl/mem_bus_bridge.sv
// Splits 32-bit core accesses into one or two 16-bit halfword bus cycles, low half first.
// Partial-halfword stores use read-modify-write when MEMBRIDGE_RMW_EN is defined.
module mem_bus_bridge
    import membus_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               core_req,
    input  logic               core_we,
    input  logic [CORE_AW-1:0] core_addr,
    input  logic [3:0]         core_be,
    input  logic [31:0]        core_wdata,
    output logic [31:0]        core_rdata,
    output logic               core_ack,
    output logic               core_err,
    output logic [MEM_AW-1:0]  New_adr,
    inout  wire  [MEM_DW-1:0]  MemData,
    output logic               MemWrite,
    output logic               MemRead
);

    membr_state_t      r_state, w_state_nx;
    logic              r_h, w_h_nx;
    logic              r_we;
    logic [18:0]       r_widx;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rbuf, w_rbuf_nx;
    logic [MEM_DW-1:0] r_wbuf, w_wbuf_nx;
    logic              r_err, w_err_nx;
    logic [MEM_AW-1:0] w_adr_nx;
    logic              w_we;
    logic [18:0]       w_widx;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic              w_enter, w_advance;
    logic [1:0]        w_hbe;
    logic [MEM_DW-1:0] w_merged;
    logic              w_unused;

    assign w_unused = ^core_addr[1:0];

    // In IDLE the decision is taken on the live request, afterwards on the latched copy.
    assign w_we    = (r_state == IDLE) ? core_we          : r_we;
    assign w_widx  = (r_state == IDLE) ? core_addr[20:2]  : r_widx;
    assign w_be    = (r_state == IDLE) ? core_be          : r_be;
    assign w_wdata = (r_state == IDLE) ? core_wdata       : r_wdata;

    assign MemData    = MemWrite ? r_wbuf : {MEM_DW{1'bz}};
    assign core_rdata = r_rbuf;
    assign core_err   = r_err;

    mem_half_merge u_merge (
        .i_old    (MemData),
        .i_new    (r_h ? r_wdata[31:16] : r_wdata[15:0]),
        .i_be     (half_be(r_be, r_h)),
        .o_merged (w_merged)
    );

    always_comb begin
        w_state_nx = r_state;
        w_h_nx     = r_h;
        w_rbuf_nx  = r_rbuf;
        w_wbuf_nx  = r_wbuf;
        w_err_nx   = r_err;
        w_adr_nx   = New_adr;
        w_enter    = 1'b0;
        w_advance  = 1'b0;
        w_hbe      = 2'b00;
        case (r_state)
            IDLE: if (core_req) begin
                w_rbuf_nx = '0;
                w_err_nx  = 1'b0;
                w_h_nx    = !half_needed(core_be, 1'b0);
                if (core_addr[31:21] != '0) begin
                    w_state_nx = ACK;
                    w_err_nx   = 1'b1;
                end else if (core_be == 4'h0) begin
                    w_state_nx = ACK;
                end else begin
                    w_enter = 1'b1;
                end
            end
            RD: if (r_we) begin
                w_wbuf_nx  = w_merged;
                w_state_nx = WR;
            end else begin
                if (r_h) w_rbuf_nx[31:16] = MemData;
                else     w_rbuf_nx[15:0]  = MemData;
                w_advance = 1'b1;
            end
            WR:      w_advance  = 1'b1;
            ACK:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase

        if (w_advance) begin
            if (!r_h && half_needed(r_be, 1'b1)) begin
                w_h_nx  = 1'b1;
                w_enter = 1'b1;
            end else begin
                w_state_nx = ACK;
            end
        end

        // Pick the bus cycle for half w_h_nx: loads read, full stores write directly.
        if (w_enter) begin
            w_hbe = half_be(w_be, w_h_nx);
            if (!w_we) begin
                w_state_nx = RD;
            end else if (w_hbe == 2'b11) begin
                w_state_nx = WR;
                w_wbuf_nx  = w_h_nx ? w_wdata[31:16] : w_wdata[15:0];
            end else begin
`ifdef MEMBRIDGE_RMW_EN
                w_state_nx = RD;
`else
                w_state_nx = WR;
                w_wbuf_nx  = w_h_nx ? w_wdata[31:16] : w_wdata[15:0];
                w_err_nx   = 1'b1;
`endif
            end
        end

        if (w_state_nx == RD || w_state_nx == WR) w_adr_nx = {w_widx, w_h_nx};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_h      <= 1'b0;
            r_rbuf   <= '0;
            r_err    <= 1'b0;
            New_adr  <= '0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            core_ack <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_h      <= w_h_nx;
            r_rbuf   <= w_rbuf_nx;
            r_err    <= w_err_nx;
            New_adr  <= w_adr_nx;
            MemRead  <= (w_state_nx == RD);
            MemWrite <= (w_state_nx == WR);
            core_ack <= (w_state_nx == ACK);
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && core_req) begin
            r_we    <= core_we;
            r_widx  <= core_addr[20:2];
            r_be    <= core_be;
            r_wdata <= core_wdata;
        end
        r_wbuf <= w_wbuf_nx;
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Scoreboard bench for mem_bus_bridge: directed accesses against a small halfword memory model.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [31:0] core_addr = '0;
    logic [3:0]  core_be = '0;
    logic [31:0] core_wdata = '0;
    logic [31:0] core_rdata;
    logic        core_ack, core_err;
    logic [19:0] New_adr;
    wire  [15:0] MemData;
    logic        MemWrite, MemRead;

`ifdef MEMBRIDGE_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    typedef struct packed { logic [31:0] rdata; logic err; int ack_cyc; } ack_t;
    typedef struct packed { logic wr; logic [19:0] adr; logic [15:0] data; } bus_t;

    ack_t        ack_q[$];
    bus_t        bus_q[$];
    logic [15:0] mem [0:1023];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          both_viol = 0;
    int          z_viol = 0;

    mem_bus_bridge dut (
        .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_be(core_be), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_ack(core_ack), .core_err(core_err),
        .New_adr(New_adr), .MemData(MemData), .MemWrite(MemWrite), .MemRead(MemRead)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign MemData = MemRead ? mem[New_adr[9:0]] : 16'hzzzz;
    always @(posedge clk) if (MemWrite) mem[New_adr[9:0]] <= MemData;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents an ack or a bus cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (core_ack) begin
                if (ack_q.size() == 0) chk("unexpected_ack", 32'd1, 32'd0);
                else begin
                    ack_t e;
                    e = ack_q.pop_front();
                    chk("ack_rdata", core_rdata, e.rdata);
                    chk("ack_err", {31'd0, core_err}, {31'd0, e.err});
                    chk("ack_cycle", cyc, e.ack_cyc);
                end
            end
            if (MemRead || MemWrite) begin
                if (bus_q.size() == 0) chk("unexpected_bus_cycle", {12'd0, New_adr}, 32'd0);
                else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    chk("bus_write", {31'd0, MemWrite}, {31'd0, b.wr});
                    chk("bus_adr", {12'd0, New_adr}, {12'd0, b.adr});
                    chk("bus_data", {16'd0, MemData}, {16'd0, b.data});
                end
            end
        end
        if (MemRead && MemWrite) both_viol++;
        if (!MemRead && !MemWrite && !($isunknown(MemData) || MemData == 16'h0000)) z_viol++;
    end

    always @(negedge clk) if (MemWrite) assert (!$isunknown(MemData)) else $error("MemData unknown during WR");

    task automatic push_bus(input logic wr, input logic [19:0] adr, input logic [15:0] data);
        bus_q.push_back('{wr: wr, adr: adr, data: data});
    endtask

    // b2b: issue at the current (ack) negedge with req still high; hold: keep req high after ack.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                          input int lat, input bit b2b, input bit hold);
        bit seen;
        if (!b2b) @(negedge clk);
        core_req = 1'b1; core_we = we; core_addr = addr; core_be = be; core_wdata = wd;
        ack_q.push_back('{rdata: exp_rd, err: exp_err, ack_cyc: cyc + lat + (b2b ? 1 : 0)});
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = core_ack;
        end
        chk("ack_seen", {31'd0, seen}, 32'd1);
        if (!hold) core_req = 1'b0;
    endtask

    logic [15:0] lo1, lo2, hi2;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        lo1 = RMW ? 16'h55EF : 16'h5500;
        lo2 = RMW ? 16'h55BB : 16'h00BB;
        hi2 = RMW ? 16'hDEAA : 16'h00AA;

        repeat (2) @(negedge clk);
        chk("rst_ack", {31'd0, core_ack}, 32'd0);
        chk("rst_err", {31'd0, core_err}, 32'd0);
        chk("rst_memread", {31'd0, MemRead}, 32'd0);
        chk("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("rst_new_adr", {12'd0, New_adr}, 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        reset = 1'b1;

        push_bus(1, 20'h00080, 16'hBEEF); push_bus(1, 20'h00081, 16'hDEAD);
        access(1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0, 3, 0, 0);
        push_bus(0, 20'h00080, 16'hBEEF); push_bus(0, 20'h00081, 16'hDEAD);
        access(0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0, 3, 0, 0);
        push_bus(0, 20'h00081, 16'hDEAD);
        access(0, 32'h100, 4'hC, 32'h0, 32'hDEAD0000, 0, 2, 0, 0);

        if (RMW) begin
            push_bus(0, 20'h00080, 16'hBEEF); push_bus(1, 20'h00080, 16'h55EF);
            access(1, 32'h100, 4'h2, 32'h00005500, 32'h0, 0, 3, 0, 0);
        end else begin
            push_bus(1, 20'h00080, 16'h5500);
            access(1, 32'h100, 4'h2, 32'h00005500, 32'h0, 1, 2, 0, 0);
        end
        push_bus(0, 20'h00080, lo1); push_bus(0, 20'h00081, 16'hDEAD);
        access(0, 32'h100, 4'hF, 32'h0, {16'hDEAD, lo1}, 0, 3, 0, 0);

        access(0, 32'h00200000, 4'hF, 32'h0, 32'h0, 1, 1, 0, 0);
        access(1, 32'h100, 4'h0, 32'hFFFFFFFF, 32'h0, 0, 1, 0, 0);
        push_bus(1, 20'h00082, 16'h5678);
        access(1, 32'h104, 4'h3, 32'h12345678, 32'h0, 0, 2, 0, 0);

        if (RMW) begin
            push_bus(0, 20'h00080, lo1);      push_bus(1, 20'h00080, lo2);
            push_bus(0, 20'h00081, 16'hDEAD); push_bus(1, 20'h00081, hi2);
            access(1, 32'h100, 4'h5, 32'h00AA00BB, 32'h0, 0, 5, 0, 0);
        end else begin
            push_bus(1, 20'h00080, lo2); push_bus(1, 20'h00081, hi2);
            access(1, 32'h100, 4'h5, 32'h00AA00BB, 32'h0, 1, 3, 0, 0);
        end
        push_bus(0, 20'h00080, lo2); push_bus(0, 20'h00081, hi2);
        access(0, 32'h100, 4'hF, 32'h0, {hi2, lo2}, 0, 3, 0, 0);

        // Reset in the second RD cycle of a word load: in-flight access is dropped.
        @(negedge clk);
        push_bus(0, 20'h00080, lo2);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; core_be = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst_memread", {31'd0, MemRead}, 32'd1);
        chk("pre_rst_new_adr", {12'd0, New_adr}, 32'h00081);
        chk("pre_rst_rdata", core_rdata, {16'h0, lo2});
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_memread", {31'd0, MemRead}, 32'd0);
        chk("mid_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        chk("mid_rst_new_adr", {12'd0, New_adr}, 32'd0);
        chk("mid_rst_ack", {31'd0, core_ack}, 32'd0);
        chk("mid_rst_err", {31'd0, core_err}, 32'd0);
        chk("mid_rst_rdata", core_rdata, 32'd0);
        core_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        push_bus(0, 20'h00080, lo2); push_bus(0, 20'h00081, hi2);
        access(0, 32'h100, 4'hF, 32'h0, {hi2, lo2}, 0, 3, 0, 0);

        push_bus(0, 20'h00082, 16'h5678);
        access(0, 32'h104, 4'h3, 32'h0, 32'h00005678, 0, 2, 0, 1);
        push_bus(0, 20'h00081, hi2);
        access(0, 32'h100, 4'hC, 32'h0, {hi2, 16'h0}, 0, 2, 1, 1);
        access(0, 32'h00400000, 4'hF, 32'h0, 32'h0, 1, 1, 1, 0);

        repeat (4) @(negedge clk);
        chk("ack_queue_empty", ack_q.size(), 32'd0);
        chk("bus_queue_empty", bus_q.size(), 32'd0);
        chk("read_write_overlap", both_viol, 32'd0);
        chk("memdata_released", z_viol, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_bridge.md
# mem_bus_bridge

Bridge between the CPU core's 32-bit data-access port and the 16-bit external memory bus (`New_adr`/`MemData`/`MemWrite`/`MemRead`) that the `dmem` model and the board memory sit on. Each accepted core access is split into one or two single-cycle halfword bus cycles, low half first. Halves with no byte enables are skipped, and responses are reassembled into one 32-bit result. The block lives inside `top` between the core load/store unit and the top-level memory pins.

## Interface
- No parameters; widths are fixed by package constants.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `core_req`  in  1  access request; held with its payload stable until `core_ack`.
- `core_we`  in  1  1 = store, 0 = load.
- `core_addr`  in  32  byte address; bits [1:0] ignored; word index = [20:2].
- `core_be`  in  4  byte enables, lane i = `core_wdata[8i+7:8i]`.
- `core_wdata`  in  32  store data, lane-positioned.
- `core_rdata`  out  32  load data, valid while `core_ack`.
- `core_ack`  out  1  one-cycle completion pulse.
- `core_err`  out  1  error flag, valid while `core_ack`.
- `New_adr`  out  20  halfword address on the bus.
- `MemData`  inout  16  bidirectional bus data.
- `MemWrite`  out  1  bus write strobe.
- `MemRead`  out  1  bus read strobe.

## Operation
- FSM states: IDLE, RD, WR, ACK. The half pointer `h` selects the current half (0 = low, 1 = high).
- IDLE with `core_req` = 1 at a rising edge:
  - Latch we, addr, be, wdata; clear the read buffer.
  - Set `h` to the first needed half: half 0 needs be[1:0] ≠ 0, half 1 needs be[3:2] ≠ 0.
- Next state after the request edge:
  - `core_addr[31:21]` ≠ 0, or be = 0: go to ACK with no bus cycle. err = 1 only for the out-of-range case.
  - Load: go to RD.
  - Store, half fully enabled: go to WR.
  - Store, half partially enabled: go to RD with `MEMBRIDGE_RMW_EN`, else WR.
- RD: `New_adr` = {word index, h}, `MemRead` = 1, `MemData` released. Memory drives combinationally; the bridge samples at the cycle end.
  - Load: store the sample into rbuf half h, then advance.
  - RMW: merge the sample with the enabled bytes into wbuf, then go to WR for the same h.
- WR: `New_adr` = {word index, h}, `MemWrite` = 1, `MemData` driven with wbuf (merged) or the latched wdata half. Then advance.
- Advance: if h = 0 and half 1 is needed, set h = 1 and re-enter the RD/WR decision; otherwise go to ACK.
- ACK:
  - `core_ack` = 1 for exactly one cycle; `core_rdata` = rbuf, with unread halves zero.
  - Return to IDLE. A `core_req` still high in ACK is not accepted; it is sampled next in IDLE.
- `MemData` is driven only in WR; it is high-Z in every other state and during reset.
- `MemRead` and `MemWrite` are never high in the same cycle.

## Timing
- Reset (`reset` = 0, asynchronous):
  - State IDLE, h = 0, rbuf = 0.
  - `core_ack`, `core_err`, `MemRead`, `MemWrite` = 0; `New_adr` = 0; `core_rdata` = 0; `MemData` = Z.
  - An access in flight is dropped with no ack. A bus cycle cut by reset is void.
- Latency from the accepting edge to `core_ack` high = (number of bus cycles + 1) cycles:
  - Full-word load/store: 3.
  - Single-half access: 2.
  - Rejected or be = 0: 1.
  - Partial stores in both halves with RMW: 5.
- Throughput: one access per (latency + 1) cycles, because of the mandatory IDLE cycle.
- All bus outputs are registered from state and come directly from flops. `MemData` capture happens at the RD cycle end, with no extra wait state.

## Configuration
- `MEMBRIDGE_RMW_EN` defined: partial-halfword stores perform a read-modify-write (RD then WR); untouched bytes are preserved and `core_err` = 0.
- `MEMBRIDGE_RMW_EN` undefined: partial-halfword stores go straight to WR with the raw wdata half. The unenabled byte of that half is overwritten, and `core_err` = 1 at ack.

## Structure
- Package `membus_pkg` holds:
  - State enum `membr_state_t` (IDLE, RD, WR, ACK).
  - `MEM_AW` = 20, `MEM_DW` = 16, `CORE_AW` = 32.
  - Function `half_needed(be, h)`.
- One sub-module, `mem_half_merge`: combinational merge of a 16-bit old half, a 16-bit new half and a 2-bit byte enable into a 16-bit result.

## Test plan
- Word store then load: addr 0x100, be 0xF, wdata 0xDEADBEEF:
  - Bus writes 0xBEEF @0x00080, then 0xDEAD @0x00081; ack 3 cycles after the request edge.
  - Load returns 0xDEADBEEF, err 0.
- High-half load, be 0xC @0x100: single RD @0x00081; rdata 0xDEAD0000; latency 2.
- Byte store with RMW, be 0x2, wdata 0x00005500 on a word holding 0xDEADBEEF:
  - RD then WR @0x00080 with 0x55EF; reload gives 0xDEAD55EF.
  - Without the macro: single WR 0x5500, err 1.
- Out-of-range addr 0x00200000: no `MemRead`/`MemWrite`; ack next cycle with err 1.
- Reset asserted during the RD of a word load: outputs drop asynchronously to the reset values, `MemData` goes Z, no ack; the next request completes normally.
- Back-to-back requests (req held high): accepts are separated by ACK + IDLE; `MemData` is never driven outside WR (checked with an X/Z assertion).
